// File: rtl/sga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sga_pkg: shared constants and state encoding for the sensor scheduler |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sga_pkg;

  localparam int N_MEDIDA = 12;

  localparam logic [3:0] EST_INICIAL      = 4'd0;
  localparam logic [3:0] EST_PREPARA      = 4'd1;
  localparam logic [3:0] EST_MEDE_ESQ     = 4'd2;
  localparam logic [3:0] EST_AGUARDA_ESQ  = 4'd3;
  localparam logic [3:0] EST_ARMAZENA_ESQ = 4'd4;
  localparam logic [3:0] EST_MEDE_DIR     = 4'd5;
  localparam logic [3:0] EST_AGUARDA_DIR  = 4'd6;
  localparam logic [3:0] EST_ARMAZENA_DIR = 4'd7;
  localparam logic [3:0] EST_LIBERA       = 4'd8;
  localparam logic [3:0] EST_ESPERA       = 4'd9;

  localparam logic [N_MEDIDA-1:0] MEDIDA_LONGE = 12'hFFF;

  localparam logic SENSOR_ESQ = 1'b0;
  localparam logic SENSOR_DIR = 1'b1;

  typedef enum logic [3:0] {
    INICIAL      = EST_INICIAL,
    PREPARA      = EST_PREPARA,
    MEDE_ESQ     = EST_MEDE_ESQ,
    AGUARDA_ESQ  = EST_AGUARDA_ESQ,
    ARMAZENA_ESQ = EST_ARMAZENA_ESQ,
    MEDE_DIR     = EST_MEDE_DIR,
    AGUARDA_DIR  = EST_AGUARDA_DIR,
    ARMAZENA_DIR = EST_ARMAZENA_DIR,
    LIBERA       = EST_LIBERA,
    ESPERA       = EST_ESPERA
  } estado_t;

  // Counter width for a modulus, never below one bit.
  function automatic int largura_min1(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/contador_m.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | contador_m: mod-M counter with synchronous clear, saturating at M-1  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module contador_m
  import sga_pkg::*;
#(
  parameter int M = 10
) (
  input  logic clock,
  input  logic reset_n,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = largura_min1(M);
  localparam logic [W-1:0] c_final = W'(M - 1);

  logic [W-1:0] r_valor;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valor <= '0;
    end else if (zera) begin
      r_valor <= '0;
    end else if (conta && !fim) begin
      r_valor <= r_valor + 1'b1;
    end
  end

  assign fim = (r_valor == c_final);

endmodule
`default_nettype wire

// File: rtl/escalonador_sensores.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | escalonador_sensores: shares one ultrasonic interface between the    |
// | left and right sensors, storing per-side results for the comparator. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module escalonador_sensores
  import sga_pkg::*;
#(
  parameter int N         = N_MEDIDA,
  parameter int INTERVALO = 2500000,
  parameter int TIMEOUT   = 1500000
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         ligar,
  input  logic         pronto,
  input  logic [N-1:0] medida,
  output logic         mede,
  output logic         sel_sensor,
  output logic [N-1:0] medida_esq,
  output logic [N-1:0] medida_dir,
  output logic         libera_alarme,
  output logic         timeout,
  output logic [3:0]   db_estado
);

  localparam logic [N-1:0] c_longe = {N{1'b1}};

  estado_t      r_estado;
  estado_t      w_proximo;
  logic         w_aguardando;
  logic         w_fim_int;
  logic         w_fim_to;
  logic         w_mede;
  logic         w_timeout;
  logic         w_captura_en;
  logic         r_sel;
  logic         r_libera;
  logic [N-1:0] r_captura;
  logic [N-1:0] r_medida_esq;
  logic [N-1:0] r_medida_dir;

  contador_m #(.M(INTERVALO)) u_cont_intervalo (
    .clock   (clock),
    .reset_n (reset_n),
    .zera    (r_estado != ESPERA),
    .conta   (r_estado == ESPERA),
    .fim     (w_fim_int)
  );

  contador_m #(.M(TIMEOUT)) u_cont_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .zera    (!w_aguardando),
    .conta   (w_aguardando),
    .fim     (w_fim_to)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= INICIAL;
    end else begin
      r_estado <= w_proximo;
    end
  end

  always_comb begin
    w_proximo    = r_estado;
    w_aguardando = (r_estado == AGUARDA_ESQ) || (r_estado == AGUARDA_DIR);
    w_mede       = (r_estado == MEDE_ESQ) || (r_estado == MEDE_DIR);
    // A same-cycle pronto suppresses the abort.
    w_timeout    = w_aguardando && w_fim_to && !pronto && ligar;
    w_captura_en = w_aguardando && (pronto || w_fim_to) && ligar;

    if (!ligar) begin
      w_proximo = INICIAL;
    end else begin
      case (r_estado)
        INICIAL:      w_proximo = PREPARA;
        PREPARA:      w_proximo = MEDE_ESQ;
        MEDE_ESQ:     w_proximo = AGUARDA_ESQ;
        AGUARDA_ESQ:  if (pronto || w_fim_to) w_proximo = ARMAZENA_ESQ;
        ARMAZENA_ESQ: w_proximo = MEDE_DIR;
        MEDE_DIR:     w_proximo = AGUARDA_DIR;
        AGUARDA_DIR:  if (pronto || w_fim_to) w_proximo = ARMAZENA_DIR;
        ARMAZENA_DIR: w_proximo = LIBERA;
        LIBERA:       w_proximo = ESPERA;
        ESPERA:       if (w_fim_int) w_proximo = MEDE_ESQ;
        default:      w_proximo = INICIAL;
      endcase
    end
  end

  // Routing only switches when a new measurement is launched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sel <= SENSOR_ESQ;
    end else if (w_proximo == MEDE_ESQ) begin
      r_sel <= SENSOR_ESQ;
    end else if (w_proximo == MEDE_DIR) begin
      r_sel <= SENSOR_DIR;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_captura <= '0;
    end else if (w_captura_en) begin
      r_captura <= pronto ? medida : c_longe;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_medida_esq <= '0;
      r_medida_dir <= '0;
    end else if (ligar) begin
      if (r_estado == ARMAZENA_ESQ) r_medida_esq <= r_captura;
      if (r_estado == ARMAZENA_DIR) r_medida_dir <= r_captura;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_libera <= 1'b0;
    end else if (w_proximo == LIBERA) begin
      r_libera <= 1'b1;
    end else if ((w_proximo == INICIAL) || (w_proximo == PREPARA)) begin
      r_libera <= 1'b0;
    end
  end

  assign mede          = w_mede;
  assign timeout       = w_timeout;
  assign sel_sensor    = r_sel;
  assign medida_esq    = r_medida_esq;
  assign medida_dir    = r_medida_dir;
  assign libera_alarme = r_libera;
  assign db_estado     = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_escalonador_sensores.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_escalonador_sensores: directed self-checking bench for the sensor |
// | scheduler (INTERVALO=20, TIMEOUT=50, N=12).                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_escalonador_sensores;

  localparam logic [3:0] S_INICIAL  = 4'd0;
  localparam logic [3:0] S_PREPARA  = 4'd1;
  localparam logic [3:0] S_MEDE_E   = 4'd2;
  localparam logic [3:0] S_AGUA_E   = 4'd3;
  localparam logic [3:0] S_ARMZ_E   = 4'd4;
  localparam logic [3:0] S_MEDE_D   = 4'd5;
  localparam logic [3:0] S_AGUA_D   = 4'd6;
  localparam logic [3:0] S_ARMZ_D   = 4'd7;
  localparam logic [3:0] S_LIBERA   = 4'd8;
  localparam logic [3:0] S_ESPERA   = 4'd9;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ligar;
  logic        pronto;
  logic [11:0] medida;
  logic        mede;
  logic        sel_sensor;
  logic [11:0] medida_esq;
  logic [11:0] medida_dir;
  logic        libera_alarme;
  logic        timeout;
  logic [3:0]  db_estado;

  int total = 0;
  int bad   = 0;
  int ciclos = 0;
  int n_mede = 0;
  int n_to   = 0;

  escalonador_sensores #(
    .N         (12),
    .INTERVALO (20),
    .TIMEOUT   (50)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ligar         (ligar),
    .pronto        (pronto),
    .medida        (medida),
    .mede          (mede),
    .sel_sensor    (sel_sensor),
    .medida_esq    (medida_esq),
    .medida_dir    (medida_dir),
    .libera_alarme (libera_alarme),
    .timeout       (timeout),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mede)    n_mede <= n_mede + 1;
    if (timeout) n_to   <= n_to + 1;
  end

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    if (obs !== esp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
    ciclos++;
  endtask

  task automatic espera_mede(input string tag);
    int n;
    n = 0;
    while (!mede && n < 200) begin
      ciclo();
      n++;
    end
    if (!mede) verifica(tag, 32'(mede), 32'd1);
  endtask

  // Sensor model: answers v after 'atraso' cycles of waiting; returns in ARMAZENA.
  task automatic responde(input logic [11:0] v, input int atraso);
    espera_mede("mede_wait");
    repeat (atraso) ciclo();
    pronto = 1'b1;
    medida = v;
    ciclo();
    pronto = 1'b0;
    medida = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int m0;
    int to0;
    int n;

    reset_n = 1'b0;
    ligar   = 1'b0;
    pronto  = 1'b0;
    medida  = '0;
    repeat (3) ciclo();
    verifica("rst_estado", 32'(db_estado), 32'(S_INICIAL));
    verifica("rst_mede", 32'(mede), 32'd0);
    verifica("rst_esq", 32'(medida_esq), 32'h000);
    verifica("rst_libera", 32'(libera_alarme), 32'd0);
    reset_n = 1'b1;
    ciclo();
    verifica("idle_hold", 32'(db_estado), 32'(S_INICIAL));

    // Test 1: normal round
    ligar = 1'b1;
    ciclo();
    verifica("t1_prepara", 32'(db_estado), 32'(S_PREPARA));
    ciclo();
    verifica("t1_mede_esq", {db_estado, 3'b0, mede, 3'b0, sel_sensor}, {S_MEDE_E, 8'h10});
    t0 = ciclos;
    m0 = n_mede;
    responde(12'h00A, 10);
    verifica("t1_armz_esq", {db_estado, 3'b0, sel_sensor}, {S_ARMZ_E, 4'h0});
    verifica("t1_esq_late", 32'(medida_esq), 32'h000);
    ciclo();
    verifica("t1_mede_dir", {db_estado, 3'b0, mede, 3'b0, sel_sensor}, {S_MEDE_D, 8'h11});
    verifica("t1_esq", 32'(medida_esq), 32'h00A);
    responde(12'h123, 10);
    verifica("t1_armz_dir", {db_estado, 3'b0, libera_alarme}, {S_ARMZ_D, 4'h0});
    ciclo();
    verifica("t1_libera", {db_estado, 3'b0, libera_alarme}, {S_LIBERA, 4'h1});
    verifica("t1_dir", 32'(medida_dir), 32'h123);
    ciclo();
    verifica("t1_espera", 32'(db_estado), 32'(S_ESPERA));

    // Test 5: spurious pronto during ESPERA
    repeat (4) ciclo();
    pronto = 1'b1;
    medida = 12'h001;
    ciclo();
    pronto = 1'b0;
    medida = '0;
    verifica("t5_esq_hold", 32'(medida_esq), 32'h00A);
    verifica("t5_dir_hold", 32'(medida_dir), 32'h123);
    verifica("t5_espera", 32'(db_estado), 32'(S_ESPERA));
    espera_mede("t5_next_mede");
    verifica("t5_gap", 32'(ciclos - t0), 32'd45);
    verifica("t5_n_mede", 32'(n_mede - m0), 32'd2);
    verifica("t5_sel", 32'(sel_sensor), 32'd0);

    // Test 2: right side never answers
    responde(12'h0B0, 10);
    ciclo();
    verifica("t2_mede_dir", 32'(db_estado), 32'(S_MEDE_D));
    to0 = n_to;
    n = 0;
    while (!timeout && n < 100) begin
      ciclo();
      n++;
    end
    verifica("t2_to_delay", 32'(n), 32'd50);
    ciclo();
    verifica("t2_armz_dir", {db_estado, 3'b0, timeout}, {S_ARMZ_D, 4'h0});
    ciclo();
    verifica("t2_dir_far", 32'(medida_dir), 32'hFFF);
    verifica("t2_libera", 32'(libera_alarme), 32'd1);
    verifica("t2_esq", 32'(medida_esq), 32'h0B0);
    ciclo();
    verifica("t2_espera", 32'(db_estado), 32'(S_ESPERA));
    verifica("t2_to_count", 32'(n_to - to0), 32'd1);

    // Test 3: pronto in the same cycle as timeout expiry
    espera_mede("t3_mede");
    to0 = n_to;
    repeat (50) ciclo();
    verifica("t3_aguarda", 32'(db_estado), 32'(S_AGUA_E));
    pronto = 1'b1;
    medida = 12'h005;
    #1;
    verifica("t3_to_low", 32'(timeout), 32'd0);
    ciclo();
    pronto = 1'b0;
    medida = '0;
    ciclo();
    verifica("t3_esq", 32'(medida_esq), 32'h005);
    verifica("t3_to_count", 32'(n_to - to0), 32'd0);

    // Test 4: ligar dropped in AGUARDA_DIR
    ciclo();
    repeat (3) ciclo();
    verifica("t4_aguarda", 32'(db_estado), 32'(S_AGUA_D));
    ligar = 1'b0;
    ciclo();
    verifica("t4_inicial", {db_estado, 3'b0, libera_alarme, 3'b0, mede, 3'b0, timeout},
             {S_INICIAL, 12'h000});
    verifica("t4_esq_hold", 32'(medida_esq), 32'h005);
    pronto = 1'b1;
    medida = 12'h777;
    ciclo();
    pronto = 1'b0;
    medida = '0;
    ciclo();
    verifica("t4_late_dir", 32'(medida_dir), 32'hFFF);
    verifica("t4_late_esq", 32'(medida_esq), 32'h005);
    ligar = 1'b1;
    ciclo();
    verifica("t4_prepara", {db_estado, 3'b0, libera_alarme}, {S_PREPARA, 4'h0});
    responde(12'h044, 10);
    ciclo();
    verifica("t4_mid_libera", 32'(libera_alarme), 32'd0);
    verifica("t4_esq_new", 32'(medida_esq), 32'h044);
    responde(12'h055, 3);
    verifica("t4_armz_libera", 32'(libera_alarme), 32'd0);
    ciclo();
    verifica("t4_libera", {db_estado, 3'b0, libera_alarme}, {S_LIBERA, 4'h1});
    verifica("t4_dir_new", 32'(medida_dir), 32'h055);

    // Test 6: asynchronous reset mid AGUARDA_ESQ
    espera_mede("t6_mede");
    ciclo();
    ciclo();
    verifica("t6_aguarda", 32'(db_estado), 32'(S_AGUA_E));
    #3;
    reset_n = 1'b0;
    #1;
    verifica("t6_async", {db_estado, 3'b0, mede, 3'b0, sel_sensor, 3'b0, libera_alarme, 3'b0, timeout},
             {S_INICIAL, 16'h0000});
    verifica("t6_regs", {8'h00, medida_esq, medida_dir}, 32'h0);
    ciclo();
    ciclo();
    verifica("t6_held", 32'(db_estado), 32'(S_INICIAL));
    reset_n = 1'b1;
    ciclo();
    verifica("t6_prepara", 32'(db_estado), 32'(S_PREPARA));
    ciclo();
    verifica("t6_mede", {db_estado, 3'b0, mede, 3'b0, sel_sensor}, {S_MEDE_E, 8'h10});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
